// File: rtl/elevator_scan.sv
// elevator_scan: N-floor SCAN elevator controller, ticked by en.
// Optional ELEVATOR_DOOR_REOPEN_EN: a call at the open floor holds the door.
module elevator_scan #(
  parameter int FLOORS        = 4,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [FLOORS-1:0] F,
  output logic [FLOORS-1:0] Q,
  output logic [FLOORS-1:0] D,
  output logic              A,
  output logic              B,
  output logic [FLOORS-1:0] pending,
  output logic              door
);

  localparam int CMAX =
    (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [CW-1:0] T_LOAD = CW'(TRAVEL_CYCLES - 1);
  localparam logic [CW-1:0] D_LOAD = CW'(DOOR_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    MOVE_UP,
    MOVE_DOWN,
    DOOR
  } state_t;

  state_t            state, state_n;
  logic              dir_up, dir_up_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [FLOORS-1:0] q_n, pend_n;
  logic [FLOORS-1:0] below_mask, above_mask;
  logic [FLOORS-1:0] f_in, q_move;
  logic              above, below;

  // Pending calls strictly above / below the current floor
  always_comb begin
    below_mask = Q - FLOORS'(1);
    above_mask = ~(Q | below_mask);
    above      = |(pending & above_mask);
    below      = |(pending & below_mask);
  end

  // Next-state, counter, position and request-latch logic
  always_comb begin
    state_n  = state;
    dir_up_n = dir_up;
    cnt_n    = cnt;
    q_n      = Q;
    pend_n   = pending;
    f_in     = (state == DOOR) ? (F & ~Q) : F;
    q_move   = (state == MOVE_UP) ? (Q << 1) : (Q >> 1);
    if (en) begin
      pend_n = pending | f_in;
      unique case (state)
        IDLE: begin
          if (|(pending & Q)) begin
            state_n = DOOR;
            pend_n  = pend_n & ~Q;
            cnt_n   = D_LOAD;
          end else if (above && (dir_up || !below)) begin
            state_n  = MOVE_UP;
            dir_up_n = 1'b1;
            cnt_n    = T_LOAD;
          end else if (below) begin
            state_n  = MOVE_DOWN;
            dir_up_n = 1'b0;
            cnt_n    = T_LOAD;
          end
        end
        MOVE_UP, MOVE_DOWN: begin
          if (cnt != '0) begin
            cnt_n = cnt - CW'(1);
          end else begin
            q_n = q_move;
            if (|(pend_n & q_move)) begin
              state_n = DOOR;
              pend_n  = pend_n & ~q_move;
              cnt_n   = D_LOAD;
            end else begin
              cnt_n = T_LOAD;
            end
          end
        end
        DOOR: begin
`ifdef ELEVATOR_DOOR_REOPEN_EN
          if (|(F & Q)) begin
            cnt_n = D_LOAD;
          end else if (cnt != '0) begin
            cnt_n = cnt - CW'(1);
          end else begin
            state_n = IDLE;
          end
`else
          if (cnt != '0) begin
            cnt_n = cnt - CW'(1);
          end else begin
            state_n = IDLE;
          end
`endif
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // State, direction, counter, floor and pending registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      dir_up  <= 1'b1;
      cnt     <= '0;
      Q       <= FLOORS'(1);
      pending <= '0;
    end else begin
      state   <= state_n;
      dir_up  <= dir_up_n;
      cnt     <= cnt_n;
      Q       <= q_n;
      pending <= pend_n;
    end
  end

  // Outputs decoded from registered state only
  always_comb begin
    A    = (state == MOVE_UP);
    B    = (state == MOVE_DOWN);
    door = (state == DOOR);
    D    = A ? (Q << 1) : (B ? (Q >> 1) : Q);
  end

endmodule

// File: tb/tb_elevator_scan.sv
// tb_elevator_scan: scoreboard bench for elevator_scan.
// Random calls/en/reset checked against a floor-level reference model.
module tb_elevator_scan;

  localparam int FL = 4;
  localparam int TC = 4;
  localparam int DC = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic [FL-1:0] F;
  logic [FL-1:0] Q, D, pending;
  logic          A, B, door;

  elevator_scan #(
    .FLOORS(FL),
    .TRAVEL_CYCLES(TC),
    .DOOR_CYCLES(DC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .en(en),
    .F(F),
    .Q(Q),
    .D(D),
    .A(A),
    .B(B),
    .pending(pending),
    .door(door)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [FL-1:0] q;
    logic [FL-1:0] d;
    logic [FL-1:0] p;
    logic          a;
    logic          b;
    logic          dr;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;

  // Reference model: floor number, call set, activity and remaining ticks
  int            m_floor;
  bit            m_calls[FL];
  int            m_act;      // 0 waiting, 1 going up, 2 going down, 3 door open
  int            m_left;
  bit            m_up;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else
      n_pass++;
  endtask

  task automatic model_step(input bit rst, input bit ena,
                            input logic [FL-1:0] f);
    bit old_calls[FL];
    bit any_above, any_below;
    if (rst) begin
      m_floor = 0;
      for (int i = 0; i < FL; i++) m_calls[i] = 0;
      m_act  = 0;
      m_left = 0;
      m_up   = 1;
      return;
    end
    if (!ena) return;
    old_calls = m_calls;
    for (int i = 0; i < FL; i++)
      if (f[i] && !(m_act == 3 && i == m_floor)) m_calls[i] = 1;
    case (m_act)
      0: begin
        any_above = 0;
        any_below = 0;
        for (int i = 0; i < FL; i++) begin
          if (old_calls[i] && i > m_floor) any_above = 1;
          if (old_calls[i] && i < m_floor) any_below = 1;
        end
        if (old_calls[m_floor]) begin
          m_calls[m_floor] = 0;
          m_act  = 3;
          m_left = DC;
        end else if (any_above && (m_up || !any_below)) begin
          m_act  = 1;
          m_up   = 1;
          m_left = TC;
        end else if (any_below) begin
          m_act  = 2;
          m_up   = 0;
          m_left = TC;
        end
      end
      1, 2: begin
        m_left--;
        if (m_left == 0) begin
          m_floor += (m_act == 1) ? 1 : -1;
          if (m_calls[m_floor]) begin
            m_calls[m_floor] = 0;
            m_act  = 3;
            m_left = DC;
          end else begin
            m_left = TC;
          end
        end
      end
      default: begin
`ifdef ELEVATOR_DOOR_REOPEN_EN
        if (f[m_floor]) m_left = DC;
        else m_left--;
`else
        m_left--;
`endif
        if (m_left == 0) m_act = 0;
      end
    endcase
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.q = '0;
    e.q[m_floor] = 1'b1;
    e.p = '0;
    for (int i = 0; i < FL; i++) e.p[i] = m_calls[i];
    e.a  = (m_act == 1);
    e.b  = (m_act == 2);
    e.dr = (m_act == 3);
    e.d  = e.q;
    if (m_act == 1) e.d = e.q << 1;
    if (m_act == 2) e.d = e.q >> 1;
    return e;
  endfunction

  // Apply one edge of stimulus and queue the model's expected response
  task automatic cycle(input bit rst, input bit ena, input logic [FL-1:0] f);
    @(negedge clk);
    reset = rst;
    en    = ena;
    F     = f;
    model_step(rst, ena, f);
    sb.push_back(model_out());
    @(posedge clk);
    #2;
  endtask

  // Monitor: compare every registered response just after the edge
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("Q", 32'(Q), 32'(e.q));
      chk("D", 32'(D), 32'(e.d));
      chk("pending", 32'(pending), 32'(e.p));
      chk("A", 32'(A), 32'(e.a));
      chk("B", 32'(B), 32'(e.b));
      chk("door", 32'(door), 32'(e.dr));
    end
  end

  initial begin
    reset = 1'b1;
    en    = 1'b1;
    F     = '1;
    model_step(1'b1, 1'b1, '1);

    cycle(1'b1, 1'b1, 4'b1111);
    cycle(1'b1, 1'b1, 4'b1111);
    chk("rst_Q", 32'(Q), 32'h1);
    chk("rst_D", 32'(D), 32'h1);
    chk("rst_flags", 32'({A, B, door}), 32'h0);
    chk("rst_pending", 32'(pending), 32'h0);

    for (int e = 1; e <= 13; e++) begin
      cycle(1'b0, 1'b1, (e == 1) ? 4'b0100 : 4'b0000);
      if (e == 1) chk("call_latch", 32'(pending), 32'h4);
      if (e == 2) chk("call_A", 32'(A), 32'h1);
      if (e == 2) chk("call_D", 32'(D), 32'h2);
      if (e == 6) chk("call_Q1", 32'(Q), 32'h2);
      if (e == 10) begin
        chk("arrive_Q", 32'(Q), 32'h4);
        chk("arrive_door", 32'(door), 32'h1);
        chk("arrive_A", 32'(A), 32'h0);
        chk("arrive_pend", 32'(pending), 32'h0);
      end
      if (e == 12) chk("door_held", 32'(door), 32'h1);
      if (e == 13) chk("door_close", 32'(door), 32'h0);
    end

    for (int n = 0; n < 4000; n++) begin
      logic [FL-1:0] f;
      bit            ena, rst;
      f   = ($urandom_range(0, 7) == 0) ? FL'($urandom) : '0;
      ena = ($urandom_range(0, 4) != 0);
      if ((n % 500) > 480) ena = 1'b0;
      rst = ($urandom_range(0, 699) == 0);
      cycle(rst, ena, f);
    end

    #3;
    chk("sb_drain", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
